// File: rtl/denoise_pkg.sv
// Shared constants, read-FSM state encoding and bank helper for the row-buffer scheduler.
package denoise_pkg;

  localparam int DEF_IMG_W = 752;
  localparam int DEF_IMG_H = 480;
  localparam int NUM_BANKS = 4;

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ADDR_W = 10;
  localparam int PIX_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ROW,
    ST_START,
    ST_RUN,
    ST_WAIT_DONE
  } state_t;

  // Bank holding row (row + ofs); offsets wrap naturally modulo NUM_BANKS.
  function automatic logic [BANK_W-1:0] bank_of(input logic [BANK_W-1:0] row_lsb,
                                                input logic [BANK_W-1:0] ofs);
    return row_lsb + ofs;
  endfunction

endpackage

// File: rtl/rowbuf_sched_if.sv
// Sensor, row-buffer and denoise-core signals of the scheduler; slave = scheduler side.
interface rowbuf_sched_if;
  import denoise_pkg::*;

  logic                frame_begin;
  logic                line_state;
  logic [PIX_W-1:0]    sensor_din;

  logic                wr_en;
  logic [BANK_W-1:0]   wr_bank;
  logic [ADDR_W-1:0]   wr_addr;
  logic [PIX_W-1:0]    wr_data;

  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [BANK_W-1:0]   rd_top_bank;
  logic [BANK_W-1:0]   rd_mid_bank;
  logic [BANK_W-1:0]   rd_bot_bank;
  logic                top_zero;
  logic                bot_zero;

  logic                core_start;
  logic                core_done;
  logic [ADDR_W-1:0]   row_idx;
  logic                frame_done;
  logic                overrun;
  logic                err_clr;

  modport slave (
    input  frame_begin, line_state, sensor_din, core_done, err_clr,
    output wr_en, wr_bank, wr_addr, wr_data,
    output rd_en, rd_addr, rd_top_bank, rd_mid_bank, rd_bot_bank, top_zero, bot_zero,
    output core_start, row_idx, frame_done, overrun
  );

  modport master (
    output frame_begin, line_state, sensor_din, core_done, err_clr,
    input  wr_en, wr_bank, wr_addr, wr_data,
    input  rd_en, rd_addr, rd_top_bank, rd_mid_bank, rd_bot_bank, top_zero, bot_zero,
    input  core_start, row_idx, frame_done, overrun
  );

endinterface

// File: rtl/rowbuf_wr_port.sv
// Sensor-side writer: one-cycle registered write port, bank = line index mod 4.
// Pixels past IMG_W are dropped; a line ends on the falling edge of line_state.
module rowbuf_wr_port
  import denoise_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic               pixclk,
  input  logic               reset_n,
  input  logic               frame_begin_i,
  input  logic               line_state_i,
  input  logic [PIX_W-1:0]   sensor_din_i,
  output logic               wr_en_o,
  output logic [BANK_W-1:0]  wr_bank_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [PIX_W-1:0]   wr_data_o,
  output logic               wr_first_o,
  output logic [ADDR_W-1:0]  wr_line_o,
  output logic [ADDR_W-1:0]  lines_written_o
);

  localparam logic [ADDR_W-1:0] W_LIM  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] H_LAST = ADDR_W'(IMG_H - 1);

  logic               frame_active_q;
  logic               line_state_q;
  logic [ADDR_W-1:0]  pix_cnt_q;
  logic [ADDR_W-1:0]  lines_q;
  logic               wr_en_q;
  logic               wr_first_q;
  logic [BANK_W-1:0]  wr_bank_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [PIX_W-1:0]   wr_data_q;
  logic [ADDR_W-1:0]  wr_line_q;

  logic accept;
  logic line_end;

  assign accept   = line_state_i & frame_active_q & (pix_cnt_q < W_LIM);
  assign line_end = line_state_q & ~line_state_i & frame_active_q;

  always_ff @(posedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      frame_active_q <= 1'b0;
      line_state_q   <= 1'b0;
      pix_cnt_q      <= '0;
      lines_q        <= '0;
      wr_en_q        <= 1'b0;
      wr_first_q     <= 1'b0;
      wr_bank_q      <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_line_q      <= '0;
    end else begin
      line_state_q <= line_state_i;
      wr_en_q      <= accept;
      wr_first_q   <= accept && (pix_cnt_q == '0);
      wr_data_q    <= sensor_din_i;
      if (accept) begin
        wr_addr_q <= pix_cnt_q;
        wr_bank_q <= lines_q[BANK_W-1:0];
        wr_line_q <= lines_q;
      end
      // Short lines still count; their unwritten addresses keep stale data.
      if (frame_begin_i) begin
        frame_active_q <= 1'b1;
        lines_q        <= '0;
        pix_cnt_q      <= '0;
      end else if (line_end) begin
        lines_q   <= lines_q + ADDR_W'(1);
        pix_cnt_q <= '0;
        if (lines_q == H_LAST) frame_active_q <= 1'b0;
      end else if (accept) begin
        pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
      end
    end
  end

  assign wr_en_o         = wr_en_q;
  assign wr_bank_o       = wr_bank_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;
  assign wr_first_o      = wr_first_q;
  assign wr_line_o       = wr_line_q;
  assign lines_written_o = lines_q;

endmodule

// File: rtl/rowbuf_sched.sv
// 3-row denoise scheduler: starts row r once row r+1 is buffered, streams IMG_W reads,
// waits for core_done. All outputs registered; frame_begin aborts and restarts the frame.
module rowbuf_sched
  import denoise_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic pixclk,
  input  logic reset_n,
  rowbuf_sched_if.slave bus
);

  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] H_LAST = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] H_ROWS = ADDR_W'(IMG_H);

  logic               wr_first;
  logic [ADDR_W-1:0]  wr_line;
  logic [ADDR_W-1:0]  lines_written;

  rowbuf_wr_port #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_wr_port (
    .pixclk          (pixclk),
    .reset_n         (reset_n),
    .frame_begin_i   (bus.frame_begin),
    .line_state_i    (bus.line_state),
    .sensor_din_i    (bus.sensor_din),
    .wr_en_o         (bus.wr_en),
    .wr_bank_o       (bus.wr_bank),
    .wr_addr_o       (bus.wr_addr),
    .wr_data_o       (bus.wr_data),
    .wr_first_o      (wr_first),
    .wr_line_o       (wr_line),
    .lines_written_o (lines_written)
  );

  state_t             state_q;
  logic [ADDR_W-1:0]  row_idx_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               rd_en_q;
  logic               core_start_q;
  logic               frame_done_q;
  logic [BANK_W-1:0]  top_bank_q;
  logic [BANK_W-1:0]  mid_bank_q;
  logic [BANK_W-1:0]  bot_bank_q;
  logic               top_zero_q;
  logic               bot_zero_q;
  logic               overrun_q;
  logic               overrun_d;

  logic               row_ready;
  logic               row_upd;
  logic [ADDR_W-1:0]  row_load;
  logic               hazard;

  // Row r needs r+1 in the buffer, except the last row which only needs the whole frame.
  assign row_ready = ({1'b0, lines_written} >= ({1'b0, row_idx_q} + 11'd2)) ||
                     ((row_idx_q == H_LAST) && (lines_written == H_ROWS));

  // Line k lands in bank k mod 4, which still holds row k-4 >= r-1 while it is needed.
  assign hazard = wr_first && (state_q != ST_IDLE) &&
                  ({1'b0, wr_line} >= ({1'b0, row_idx_q} + 11'd3));

  always_comb begin
    row_upd  = bus.frame_begin || ((state_q == ST_WAIT_DONE) && bus.core_done);
    row_load = bus.frame_begin ? '0 : (row_idx_q + ADDR_W'(1));
  end

  always_comb begin
    overrun_d = overrun_q;
    if (bus.err_clr || bus.frame_begin) overrun_d = 1'b0;
    if (hazard)                         overrun_d = 1'b1;
  end

  always_ff @(posedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      row_idx_q    <= '0;
      rd_addr_q    <= '0;
      rd_en_q      <= 1'b0;
      core_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      top_bank_q   <= '0;
      mid_bank_q   <= '0;
      bot_bank_q   <= '0;
      top_zero_q   <= 1'b0;
      bot_zero_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= overrun_d;

      if (row_upd) begin
        row_idx_q  <= row_load;
        mid_bank_q <= bank_of(row_load[BANK_W-1:0], BANK_W'(0));
        top_bank_q <= bank_of(row_load[BANK_W-1:0], BANK_W'(NUM_BANKS - 1));
        bot_bank_q <= bank_of(row_load[BANK_W-1:0], BANK_W'(1));
        top_zero_q <= (row_load == '0);
        bot_zero_q <= (row_load == H_LAST);
      end

      if (bus.frame_begin) begin
        state_q   <= ST_WAIT_ROW;
        rd_en_q   <= 1'b0;
        rd_addr_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_WAIT_ROW: begin
            if (row_ready) begin
              state_q      <= ST_START;
              core_start_q <= 1'b1;
            end
          end
          ST_START: begin
            state_q   <= ST_RUN;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
          end
          ST_RUN: begin
            if (rd_addr_q == W_LAST) begin
              rd_en_q <= 1'b0;
              state_q <= ST_WAIT_DONE;
            end else begin
              rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
          end
          ST_WAIT_DONE: begin
            if (bus.core_done) begin
              if (row_load == H_ROWS) begin
                frame_done_q <= 1'b1;
                state_q      <= ST_IDLE;
              end else begin
                state_q <= ST_WAIT_ROW;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.rd_top_bank = top_bank_q;
  assign bus.rd_mid_bank = mid_bank_q;
  assign bus.rd_bot_bank = bot_bank_q;
  assign bus.top_zero    = top_zero_q;
  assign bus.bot_zero    = bot_zero_q;
  assign bus.core_start  = core_start_q;
  assign bus.row_idx     = row_idx_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_rowbuf_sched.sv
// Directed bench for rowbuf_sched at IMG_W=8, IMG_H=4 with a simple core-done responder.
module tb_rowbuf_sched;

  logic pixclk;
  logic reset_n;

  rowbuf_sched_if bus();

  rowbuf_sched #(
    .IMG_W (8),
    .IMG_H (4)
  ) dut (
    .pixclk  (pixclk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    pixclk = 1'b0;
    forever #5 pixclk = ~pixclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int vec_cnt    = 0;
  int miscmp_cnt = 0;

  int         starts, dones, wr_cnt, rd_gap, run_len, resp_cnt;
  bit         resp_en;
  logic       rd_en_prev;
  logic [9:0] exp_rd;
  logic [7:0] mem [4][16];
  logic [9:0] st_row [8];
  logic       st_tz  [8];
  logic       st_bz  [8];
  logic [1:0] st_top [8];
  logic [1:0] st_mid [8];
  logic [1:0] st_bot [8];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_counters();
    starts = 0; dones = 0; wr_cnt = 0; rd_gap = 0; run_len = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 16; a++) mem[b][a] = 8'hEE;
  endtask

  // Advance one cycle, sample 1 ns after the edge, then drive the core responder.
  task automatic tick();
    @(posedge pixclk);
    #1;
    if (bus.core_start) begin
      if (starts < 8) begin
        st_row[starts] = bus.row_idx;
        st_tz[starts]  = bus.top_zero;
        st_bz[starts]  = bus.bot_zero;
        st_top[starts] = bus.rd_top_bank;
        st_mid[starts] = bus.rd_mid_bank;
        st_bot[starts] = bus.rd_bot_bank;
      end
      starts++;
    end
    if (bus.frame_done) dones++;
    if (bus.rd_en) begin
      if (!rd_en_prev) begin exp_rd = '0; run_len = 0; end
      if (bus.rd_addr != exp_rd) rd_gap++;
      exp_rd = exp_rd + 10'd1;
      run_len++;
    end
    if (bus.wr_en) begin
      wr_cnt++;
      if (bus.wr_addr < 10'd16) mem[bus.wr_bank][bus.wr_addr[3:0]] = bus.wr_data;
    end
    bus.core_done = 1'b0;
    if (resp_en) begin
      if (rd_en_prev && !bus.rd_en) resp_cnt = 3;
      else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) bus.core_done = 1'b1;
      end
    end
    rd_en_prev = bus.rd_en;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      bus.line_state = 1'b1;
      bus.sensor_din = base + 8'(i);
      tick();
    end
    bus.line_state = 1'b0;
    tick();
  endtask

  task automatic pulse_frame_begin();
    bus.frame_begin = 1'b1;
    tick();
    bus.frame_begin = 1'b0;
  endtask

  task automatic full_frame(input logic [7:0] base);
    for (int l = 0; l < 4; l++) begin
      send_line(8, base + 8'(l * 16));
      idle(20);
    end
    for (int k = 0; k < 200 && dones < 1; k++) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    bus.frame_begin = 1'b0; bus.line_state = 1'b0; bus.sensor_din = '0;
    bus.core_done = 1'b0; bus.err_clr = 1'b0;
    resp_en = 1'b0; resp_cnt = 0; rd_en_prev = 1'b0; exp_rd = '0;
    clear_counters();
    idle(3);
    check_vec("rst_ctl", {bus.wr_en, bus.rd_en, bus.core_start, bus.frame_done,
                          bus.overrun, bus.top_zero, bus.bot_zero}, 0);
    check_vec("rst_row", bus.row_idx, 0);
    check_vec("rst_banks", {bus.rd_top_bank, bus.rd_mid_bank, bus.rd_bot_bank}, 0);
    check_vec("rst_bus", {bus.wr_bank, bus.wr_addr, bus.wr_data, bus.rd_addr}, 0);
    reset_n = 1'b1;
    idle(2);

    // No frame_begin yet: lines must be ignored.
    send_line(4, 8'h55);
    idle(4);
    check_vec("pre_frame_wr", wr_cnt, 0);
    check_vec("pre_frame_st", starts, 0);

    // Normal frame, checking the row-0 start instant by hand.
    pulse_frame_begin();
    check_vec("fb_row0", {bus.row_idx, bus.top_zero, bus.bot_zero}, {10'd0, 1'b1, 1'b0});
    resp_en = 1'b1;
    send_line(8, 8'h10);
    idle(2);
    check_vec("one_line_st", starts, 0);
    send_line(8, 8'h20);
    check_vec("st_early", bus.core_start, 0);
    tick();
    check_vec("st_row0", bus.core_start, 1);
    check_vec("row0_banks", {bus.rd_top_bank, bus.rd_mid_bank, bus.rd_bot_bank}, {2'd3, 2'd0, 2'd1});
    tick();
    check_vec("run_first", {bus.rd_en, bus.rd_addr}, {1'b1, 10'd0});
    idle(20);
    send_line(8, 8'h30);
    idle(20);
    send_line(8, 8'h40);
    for (int k = 0; k < 200 && dones < 1; k++) tick();
    check_vec("a_starts", starts, 4);
    check_vec("a_dones", dones, 1);
    check_vec("a_rows", {st_row[0], st_row[1], st_row[2], st_row[3]},
                        {10'd0, 10'd1, 10'd2, 10'd3});
    check_vec("a_topzero", {st_tz[0], st_tz[1], st_tz[2], st_tz[3]}, 4'b1000);
    check_vec("a_botzero", {st_bz[0], st_bz[1], st_bz[2], st_bz[3]}, 4'b0001);
    check_vec("row1_banks", {st_top[1], st_mid[1], st_bot[1]}, {2'd0, 2'd1, 2'd2});
    check_vec("row3_banks", {st_top[3], st_mid[3], st_bot[3]}, {2'd2, 2'd3, 2'd0});
    check_vec("a_runlen", run_len, 8);
    check_vec("a_rdgap", rd_gap, 0);
    check_vec("a_wrcnt", wr_cnt, 32);
    check_vec("a_mem", {mem[0][0], mem[1][7], mem[2][4], mem[3][0]},
                       {8'h10, 8'h27, 8'h34, 8'h40});
    check_vec("a_overrun", bus.overrun, 0);
    idle(10);
    check_vec("a_no_extra", {starts[7:0], dones[7:0]}, {8'd4, 8'd1});

    // Long line truncation, then withheld core_done leading to overrun.
    resp_en = 1'b0;
    pulse_frame_begin();
    clear_counters();
    send_line(10, 8'hA0);
    idle(1);
    check_vec("long_wrcnt", wr_cnt, 8);
    check_vec("long_mem", {mem[0][0], mem[0][7], mem[0][8], mem[0][9]},
                          {8'hA0, 8'hA7, 8'hEE, 8'hEE});
    send_line(8, 8'hB0);
    idle(12);
    check_vec("next_line", {mem[1][0], mem[1][7], mem[0][0]}, {8'hB0, 8'hB7, 8'hA0});
    check_vec("b_wrcnt", wr_cnt, 16);
    check_vec("b_starts", starts, 1);
    send_line(8, 8'hC0);
    idle(2);
    check_vec("ovr_line2", bus.overrun, 0);
    bus.line_state = 1'b1;
    bus.sensor_din = 8'hD0;
    tick();
    check_vec("ovr_pre", bus.overrun, 0);
    bus.sensor_din = 8'hD1;
    tick();
    check_vec("ovr_set", bus.overrun, 1);
    for (int i = 2; i < 8; i++) begin
      bus.sensor_din = 8'hD0 + 8'(i);
      tick();
    end
    bus.line_state = 1'b0;
    idle(4);
    check_vec("ovr_sticky", bus.overrun, 1);
    check_vec("ovr_wr_goes", {mem[3][0], mem[3][7]}, {8'hD0, 8'hD7});
    check_vec("ovr_row", {bus.row_idx, starts[7:0]}, {10'd0, 8'd1});
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check_vec("ovr_clr", bus.overrun, 0);
    idle(2);
    check_vec("ovr_stays", bus.overrun, 0);

    // Abort mid-RUN, then a clean frame.
    pulse_frame_begin();
    clear_counters();
    resp_en = 1'b1;
    send_line(8, 8'h11);
    send_line(8, 8'h22);
    for (int k = 0; k < 10 && starts < 1; k++) tick();
    idle(3);
    check_vec("abort_pre", bus.rd_en, 1);
    pulse_frame_begin();
    check_vec("abort_rden", bus.rd_en, 0);
    check_vec("abort_row", bus.row_idx, 0);
    idle(10);
    check_vec("abort_quiet", {starts[7:0], dones[7:0], 1'b0, bus.rd_en}, {8'd1, 8'd0, 2'b00});
    check_vec("abort_row_hold", bus.row_idx, 0);
    clear_counters();
    full_frame(8'h60);
    check_vec("d_count", {starts[7:0], dones[7:0]}, {8'd4, 8'd1});
    check_vec("d_rows", {st_row[0], st_row[3]}, {10'd0, 10'd3});
    check_vec("d_runlen", {run_len[7:0], rd_gap[7:0]}, {8'd8, 8'd0});

    // Asynchronous reset in WAIT_DONE, then a stray core_done.
    resp_en = 1'b0;
    pulse_frame_begin();
    clear_counters();
    send_line(8, 8'h01);
    send_line(8, 8'h02);
    idle(14);
    check_vec("e_pre", {bus.top_zero, bus.rd_bot_bank, bus.wr_addr}, {1'b1, 2'd1, 10'd7});
    #2;
    reset_n = 1'b0;
    #1;
    check_vec("e_rst_ctl", {bus.wr_en, bus.rd_en, bus.core_start, bus.frame_done,
                            bus.overrun, bus.top_zero, bus.bot_zero}, 0);
    check_vec("e_rst_bus", {bus.rd_top_bank, bus.rd_bot_bank, bus.wr_addr, bus.row_idx}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    clear_counters();
    bus.core_done = 1'b1;
    tick();
    idle(5);
    check_vec("e_stray_done", {bus.row_idx, starts[7:0], dones[7:0]}, 0);
    send_line(8, 8'h77);
    idle(3);
    check_vec("e_no_frame_wr", {wr_cnt[7:0], starts[7:0]}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
